// File: rtl/mc_ctrl_pkg.sv
// Shared state, opcode and mux-select encodings for the multicycle control unit and sign-extender.
// ILLEGAL_OPCODE_TRAP_EN adds the TRAP state to the enumeration.
package mc_ctrl_pkg;

  localparam int STATE_W = 5;

  typedef enum logic [STATE_W-1:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_UPPER,
    S_ALUWB,
    S_JAL,
    S_JALR,
    S_JALRPC,
    S_BRANCH
`ifdef ILLEGAL_OPCODE_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] RES_ALUOUT  = 2'd0;
  localparam logic [1:0] RES_MEMDATA = 2'd1;
  localparam logic [1:0] RES_ALU     = 2'd2;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  function automatic logic is_known_op(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL,
      OP_JALR, OP_BRANCH, OP_LUI, OP_AUIPC: is_known_op = 1'b1;
      default:                              is_known_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state logic for the multicycle control FSM; memory phases hold until mem_ready.
// ILLEGAL_OPCODE_TRAP_EN routes unknown opcodes to a TRAP state that only reset leaves.
module mc_next_state
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output state_t     next_state
);

  always_comb begin
    next_state = state;
    case (state)
      S_START:    next_state = S_FETCH;
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_LUI, OP_AUIPC:  next_state = S_UPPER;
`ifdef ILLEGAL_OPCODE_TRAP_EN
          default:           next_state = S_TRAP;
`else
          default:           next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
      S_EXECR,
      S_EXECI,
      S_UPPER,
      S_JAL,
      S_JALRPC:   next_state = S_ALUWB;
      S_JALR:     next_state = S_JALRPC;
      S_ALUWB,
      S_BRANCH:   next_state = S_FETCH;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      S_TRAP:     next_state = S_TRAP;
`endif
      default:    next_state = S_START;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the shared RISC-V multicycle datapath; outputs decode from state, memory enables gated by mem_ready.
// ILLEGAL_OPCODE_TRAP_EN enables the sticky illegal_instr trap; otherwise unknown opcodes retire as NOPs.
module multicycle_control_unit #(
  parameter int STATE_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       mem_req,
  output logic       instr_done,
  output logic       illegal_instr
);

  import mc_ctrl_pkg::*;

  logic [STATE_W-1:0] state_q;
  state_t             state;
  state_t             next_state;

  assign state = state_t'(state_q);

  mc_next_state u_next_state (
    .state      (state),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .next_state (next_state)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= STATE_W'(S_START);
    else        state_q <= STATE_W'(next_state);
  end

  always_comb begin
    imm_src       = IMM_I;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALU_ADD;
    result_src    = RES_ALUOUT;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    mem_req       = 1'b0;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        // Precompute the branch/jump target into ALUOut while decoding.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
`ifndef ILLEGAL_OPCODE_TRAP_EN
        instr_done = !is_known_op(opcode);
`endif
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_LOAD) ? IMM_I : IMM_S;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        adr_src    = 1'b1;
        mem_write  = mem_ready;
        instr_done = mem_ready;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_UPPER: begin
        imm_src   = IMM_U;
        alu_src_b = SRCB_IMM;
        alu_src_a = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_JALRPC: begin
        // PC takes the rs1+imm target from ALUOut while the ALU forms the link value.
        pc_write  = 1'b1;
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALU_SUB;
        pc_write   = ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
        instr_done = 1'b1;
      end
`ifdef ILLEGAL_OPCODE_TRAP_EN
      S_TRAP: illegal_instr = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench: builds per-instruction expected output traces from the ISA phase rules and checks the DUT every cycle.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic [2:0] imm_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       adr_src, ir_write, pc_write, reg_write, mem_write, mem_req, instr_done, illegal_instr;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .mem_write(mem_write), .mem_req(mem_req), .instr_done(instr_done),
    .illegal_instr(illegal_instr)
  );

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, BAD = 7'b1111111;

  typedef struct packed {
    logic [2:0] imm;
    logic [1:0] a, b, op, res;
    logic       adr, irw, pcw, rw, mw, mreq, done, ill;
  } exp_t;

  typedef struct {
    exp_t       e;
    logic       mr, z, rst, chk, start;
    logic [6:0] opc;
    logic [2:0] f3;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  bit   cur_vld = 0;
  int   tests = 0, errors = 0, cyc = 0, last_cpi = -1;

  function automatic bit rb();
    return 1'($urandom_range(1));
  endfunction

  function automatic bit known(input logic [6:0] o);
    return o inside {LW, SW, RT, IT, JAL, JALR, BR, LUI, AUIPC};
  endfunction

  task automatic push(input exp_t e, input logic [6:0] opc, input logic [2:0] f3, input logic mr,
                      input logic z, input bit start = 1'b0, input bit rst = 1'b1, input bit chk = 1'b1);
    ent_t t;
    t.e = e; t.opc = opc; t.f3 = f3; t.mr = mr; t.z = z;
    t.start = start; t.rst = rst; t.chk = chk;
    q.push_back(t);
  endtask

  // Reset held low n cycles; the first low cycle's outputs are not checked (state may be mid-flight or unknown).
  task automatic gen_reset(input int n);
    push('0, 7'($urandom), 3'($urandom), rb(), rb(), 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < n; i++) push('0, 7'($urandom), 3'($urandom), rb(), rb(), 1'b0, 1'b0);
    push('0, 7'($urandom), 3'($urandom), rb(), rb());
  endtask

  // Expected cycle-by-cycle outputs of one instruction: fetch with sf stalls, memory phase with sm stalls.
  task automatic gen_instr(input logic [6:0] opc, input logic [2:0] f3, input logic z, input int sf, input int sm);
    exp_t e;
    e = '0; e.mreq = 1; e.b = 2; e.res = 2;
    for (int i = 0; i < sf; i++) push(e, 7'($urandom), 3'($urandom), 1'b0, rb(), i == 0);
    e.irw = 1; e.pcw = 1;
    push(e, 7'($urandom), 3'($urandom), 1'b1, rb(), sf == 0);
    e = '0; e.a = 1; e.b = 1; e.imm = (opc == JAL) ? 3'd4 : 3'd2;
    if (!known(opc)) begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
      push(e, opc, f3, rb(), rb());
      e = '0; e.ill = 1;
      for (int i = 0; i < 10; i++) push(e, opc, f3, rb(), rb());
      push(e, opc, f3, rb(), rb(), 1'b0, 1'b0);
      push('0, opc, f3, rb(), rb());
`else
      e.done = 1;
      push(e, opc, f3, rb(), rb());
`endif
      return;
    end
    push(e, opc, f3, rb(), rb());
    e = '0;
    if (opc == LW || opc == SW) begin
      e.a = 2; e.b = 1; e.imm = (opc == LW) ? 3'd0 : 3'd1;
      push(e, opc, f3, rb(), rb());
      e = '0; e.mreq = 1; e.adr = 1;
      for (int i = 0; i < sm; i++) push(e, opc, f3, 1'b0, rb());
      if (opc == SW) begin
        e.mw = 1; e.done = 1;
        push(e, opc, f3, 1'b1, rb());
      end else begin
        push(e, opc, f3, 1'b1, rb());
        e = '0; e.res = 1; e.rw = 1; e.done = 1;
        push(e, opc, f3, rb(), rb());
      end
      return;
    end
    if (opc == BR) begin
      e.a = 2; e.op = 1; e.done = 1;
      e.pcw = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
      push(e, opc, f3, rb(), z);
      return;
    end
    case (opc)
      RT:         begin e.a = 2; e.op = 2; end
      IT:         begin e.a = 2; e.b = 1; e.op = 2; end
      LUI, AUIPC: begin e.imm = 3; e.b = 1; e.a = (opc == LUI) ? 2'd3 : 2'd1; end
      JAL:        begin e.a = 1; e.b = 2; e.pcw = 1; end
      default: begin
        e.a = 2; e.b = 1;
        push(e, opc, f3, rb(), rb());
        e = '0; e.pcw = 1; e.a = 1; e.b = 2;
      end
    endcase
    push(e, opc, f3, rb(), rb());
    e = '0; e.rw = 1; e.done = 1;
    push(e, opc, f3, rb(), rb());
  endtask

  task automatic run();
    last_cpi = -1;
    while (q.size() > 0) begin
      @(negedge clk);
      cur = q.pop_front();
      reset = cur.rst; mem_ready = cur.mr; zero = cur.z; opcode = cur.opc; funct3 = cur.f3;
      cur_vld = 1;
    end
    #3;
    cur_vld = 0;
  endtask

  task automatic chk_cpi(input string nm, input int expv);
    tests++;
    if (last_cpi != expv) begin
      errors++;
      $display("FAIL cpi_%s: got %0d cycles, expected %0d", nm, last_cpi, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t act;
    #2;
    if (cur_vld) begin
      cyc = cur.start ? 1 : cyc + 1;
      if (cur.chk) begin
        act = '{imm: imm_src, a: alu_src_a, b: alu_src_b, op: alu_op, res: result_src, adr: adr_src,
                irw: ir_write, pcw: pc_write, rw: reg_write, mw: mem_write, mreq: mem_req,
                done: instr_done, ill: illegal_instr};
        tests++;
        if (act !== cur.e) begin
          errors++;
          $display("FAIL outputs t=%0t op=%b f3=%b mr=%b z=%b rst=%b: got %h expected %h",
                   $time, cur.opc, cur.f3, cur.mr, cur.z, cur.rst, act, cur.e);
        end
      end
      if (instr_done === 1'b1 && cur.rst) last_cpi = cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops[10] = '{LW, SW, RT, IT, JAL, JALR, BR, LUI, AUIPC, BAD};
    logic [6:0] op;
    int keep, base;
    reset = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct3 = '0;

    gen_reset(2);
    gen_instr(LW, 3'b010, 1'b0, 0, 0);  run(); chk_cpi("lw", 5);
    gen_instr(SW, 3'b010, 1'b0, 0, 3);  run(); chk_cpi("sw_stall3", 7);
    gen_instr(LW, 3'b010, 1'b0, 2, 1);  run(); chk_cpi("lw_stalls", 8);
    gen_instr(BR, 3'b000, 1'b1, 0, 0);  run(); chk_cpi("beq_taken", 3);
    gen_instr(BR, 3'b000, 1'b0, 0, 0);  run(); chk_cpi("beq_not", 3);
    gen_instr(BR, 3'b001, 1'b0, 0, 0);  run(); chk_cpi("bne_taken", 3);
    gen_instr(BR, 3'b001, 1'b1, 0, 0);  run(); chk_cpi("bne_not", 3);
    gen_instr(BR, 3'b100, 1'b0, 0, 0);  run(); chk_cpi("blt_never", 3);
    gen_instr(JAL, 3'b000, 1'b0, 0, 0); run(); chk_cpi("jal", 4);
    gen_instr(JALR, 3'b000, 1'b0, 0, 0); run(); chk_cpi("jalr", 5);
    gen_instr(LUI, 3'b000, 1'b0, 0, 0); run(); chk_cpi("lui", 4);
    gen_instr(AUIPC, 3'b000, 1'b0, 0, 0); run(); chk_cpi("auipc", 4);
    gen_instr(RT, 3'b000, 1'b0, 0, 0);  run(); chk_cpi("rtype", 4);
    gen_instr(IT, 3'b000, 1'b0, 0, 0);  run(); chk_cpi("itype", 4);
    gen_instr(BAD, 3'b000, 1'b0, 0, 0); run();
`ifndef ILLEGAL_OPCODE_TRAP_EN
    chk_cpi("nop", 2);
`endif

    for (int n = 0; n < 150; n++) begin
      op = ($urandom_range(7) == 0) ? 7'($urandom) : ops[$urandom_range(9)];
      base = q.size();
      gen_instr(op, 3'($urandom), rb(), $urandom_range(2), $urandom_range(3));
      if ($urandom_range(9) == 0) begin
        keep = $urandom_range(1, q.size() - base);
        while (q.size() > base + keep) void'(q.pop_back());
        q[q.size() - 1].rst = 1'b0;
        push('0, 7'($urandom), 3'($urandom), rb(), rb());
      end
      run();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore FSM that sequences the shared RISC-V multicycle datapath: one ALU, one unified memory port, and the immediate sign-extender.
- Drives imm_src (sign-extender select), ALU operand muxes, write enables and the memory address mux per instruction phase.
- Stalls on memory with a ready handshake; sits beside the datapath, fed by the instruction register fields and the ALU zero flag.

Parameters:
- STATE_W, 5, width of the state register.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- opcode  input  7  instr[6:0] from instruction register
- funct3  input  3  instr[14:12]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes access this cycle
- imm_src  output  3  sign-extender select: I=0 S=1 B=2 U=3 J=4
- alu_src_a  output  2  0 PC, 1 oldPC, 2 rs1 reg, 3 zero
- alu_src_b  output  2  0 rs2 reg, 1 imm, 2 constant 4
- alu_op  output  2  0 add, 1 sub, 2 decode funct
- result_src  output  2  0 ALUOut, 1 mem data, 2 ALU result
- adr_src  output  1  0 PC, 1 result
- ir_write, pc_write, reg_write, mem_write, mem_req  output  1 each
- instr_done  output  1  one-cycle pulse when an instruction retires
- illegal_instr  output  1  sticky flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset low at a clk edge -> state START. START drives all outputs 0 and goes to FETCH next cycle. Reset mid-instruction aborts with no further enables.
- Unlisted outputs are 0 in every state.
- FETCH: mem_req=1, adr_src=0, alu_src_a=0, alu_src_b=2, alu_op=0, result_src=2.
  - ir_write and pc_write are asserted only when mem_ready=1; then go to DECODE.
  - mem_ready=0: hold in FETCH with both enables low.
- DECODE: alu_src_a=1, alu_src_b=1, alu_op=0; imm_src=J if opcode=1101111, else B. Next state by opcode:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 1100011 -> BRANCH
  - 0110111 / 0010111 -> UPPER
  - else -> FETCH (NOP, instr_done=1)
- MEMADR: alu_src_a=2, alu_src_b=1, imm_src=I for load, S for store -> MEMREAD or MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=0; -> MEMWB on mem_ready, else hold.
- MEMWB: result_src=1, reg_write=1, instr_done=1 -> FETCH.
- MEMWRITE: mem_req=1, adr_src=1; mem_write=1 gated by mem_ready; on ready instr_done=1 -> FETCH.
- EXECR: alu_src_a=2, alu_src_b=0, alu_op=2 -> ALUWB.
- EXECI: alu_src_a=2, alu_src_b=1, imm_src=I, alu_op=2 -> ALUWB.
- UPPER: imm_src=U, alu_src_b=1, alu_op=0; alu_src_a=3 for LUI, 1 for AUIPC -> ALUWB.
- ALUWB: result_src=0, reg_write=1, instr_done=1 -> FETCH.
- JAL: alu_src_a=1, alu_src_b=2, result_src=0, pc_write=1 -> ALUWB. rd gets oldPC+4.
- JALR: alu_src_a=2, alu_src_b=1, imm_src=I, alu_op=0 -> JALRPC.
- JALRPC: result_src=0, pc_write=1, alu_src_a=1, alu_src_b=2 -> ALUWB.
- BRANCH: alu_src_a=2, alu_src_b=0, alu_op=1, result_src=0.
  - pc_write = (funct3=000 & zero) | (funct3=001 & ~zero); any other funct3 is not taken.
  - instr_done=1 -> FETCH.
- CPI: load 5, store 4, R/I/U 4, branch 3, JAL 4, JALR 5, plus added cycles per mem_ready=0.

Optional Feature:
- ILLEGAL_OPCODE_TRAP_EN
  - Defined: an unknown opcode in DECODE -> TRAP. TRAP drives all enables 0 and sets illegal_instr=1. The FSM stays in TRAP until reset; reset clears the flag.
  - Undefined: an unknown opcode is a NOP as above; illegal_instr is constant 0 and no TRAP state exists.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enumeration (STATE_W)
  - opcode constants
  - imm_src codes I/S/B/U/J = 0..4 (shared with the sign-extender)
  - alu_src_a/alu_src_b/result_src/alu_op encodings
- Optional sub-module mc_next_state: combinational next-state logic. The top holds the state register and the output decode.

Test Plan:
- Reset low 2 cycles then high, mem_ready=1 -> START outputs all 0, FETCH next cycle, ir_write=pc_write=1 in that cycle.
- lw opcode 0000011, mem_ready=1 -> states FETCH, DECODE, MEMADR (imm_src=0), MEMREAD, MEMWB (reg_write=1, result_src=1); instr_done after 5 cycles.
- sw 0100011 with mem_ready held 0 for 3 cycles in MEMWRITE -> imm_src=1, mem_write stays 0 until ready, then one pulse; total 7 cycles.
- beq funct3=000: zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0; bne funct3=001 gives the inverse; 3 cycles each.
- jal 1101111 -> DECODE imm_src=4, JAL pc_write=1, ALUWB reg_write=1; lui 0110111 -> UPPER alu_src_a=3, imm_src=3.
- opcode 1111111 -> without macro: returns to FETCH, instr_done=1. With ILLEGAL_OPCODE_TRAP_EN: TRAP, illegal_instr=1 held 10 cycles, cleared by reset.
